pipeline_top: RTL and testbench

PIPELINE_TOP -- requirements
Module: pipeline_top

---
 rtl/pipeline_top.sv | 267 ++++++++++++++++++++++++++
 tb/tb_pipeline_top.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_top.sv
// Five-stage in-order RV32I subset pipeline (IF/ID/EX/MEM/WB) with operand forwarding,
// a one-cycle load-use interlock and branch/JAL redirect resolved in EX.

module mem_core #(parameter int DEPTH = 256) (
    input  logic        CLK,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [31:0] raddr,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   RAM_matrix [0:DEPTH-1];
    logic [AW-1:0] widx;
    logic [AW-1:0] ridx;

    // Byte address -> word index, wrapped to the array depth.
    assign widx  = AW'((waddr >> 2) % 32'(DEPTH));
    assign ridx  = AW'((raddr >> 2) % 32'(DEPTH));
    assign rdata = RAM_matrix[ridx];

    always_ff @(posedge CLK) begin
        if (we) RAM_matrix[widx] <= wdata;
    end
endmodule

module mem_wrap #(parameter int DEPTH = 256) (
    input  logic        CLK,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [31:0] raddr,
    output logic [31:0] rdata
);
    mem_core #(.DEPTH(DEPTH)) sub1 (.*);
endmodule

module pc_reg (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] D,
    output logic [31:0] OUT
);
    logic [31:0] out_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) out_q <= 32'd0;
        else     out_q <= D;
    end
    assign OUT = out_q;
endmodule

module regfile (
    input  logic        CLK,
    input  logic        RST,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (we && waddr != 5'd0) begin
            registers[waddr] <= wdata;
        end
    end

    // Same-cycle write is bypassed so ID sees the value WB is committing.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : (we && waddr == ra1) ? wdata : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : (we && waddr == ra2) ? wdata : registers[ra2];
endmodule

module pipeline_top #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic CLK,
    input logic RST
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_t;
    typedef struct packed {
        logic reg_we, mem_re, mem_we, branch, bne, jal, lui, use_imm;
        alu_op_t alu;
    } ctl_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ifid_t;
    typedef struct packed {
        ctl_t ctl; logic [4:0] rs1, rs2, rd; logic [31:0] pc, a, b, imm;
    } idex_t;
    typedef struct packed {
        logic reg_we, mem_re, mem_we; logic [4:0] rd; logic [31:0] alu, sd;
    } exmem_t;
    typedef struct packed { logic reg_we; logic [4:0] rd; logic [31:0] res; } memwb_t;

    localparam ifid_t IFID_BUBBLE = '{pc: 32'd0, inst: 32'h0000_0013};

    logic [31:0] pc_cur, pc_d, imem_rdata, dmem_rdata, rf_rd1, rf_rd2;
    ifid_t  ifid_q,  ifid_d;
    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic [31:0] inst, dec_imm;
    ctl_t        dec_ctl;
    logic        uses_rs1, uses_rs2, load_use, taken;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_out, ex_res, target, mem_res;

    pc_reg PC (.CLK, .RST, .D(pc_d), .OUT(pc_cur));
    mem_wrap #(.DEPTH(IMEM_WORDS)) INST_MEM (.CLK, .we(1'b0), .waddr(32'd0), .wdata(32'd0),
                                            .raddr(pc_cur), .rdata(imem_rdata));
    mem_wrap #(.DEPTH(DMEM_WORDS)) DATA_MEM (.CLK, .we(exmem_q.mem_we), .waddr(exmem_q.alu),
                                            .wdata(exmem_q.sd), .raddr(exmem_q.alu), .rdata(dmem_rdata));
    regfile register_file (.CLK, .RST, .we(memwb_q.reg_we), .waddr(memwb_q.rd), .wdata(memwb_q.res),
                           .ra1(inst[19:15]), .ra2(inst[24:20]), .rd1(rf_rd1), .rd2(rf_rd2));

    assign inst = ifid_q.inst;

    // ID: unsupported encodings leave dec_ctl all-zero, i.e. a NOP.
    always_comb begin
        dec_ctl  = '0;
        dec_imm  = {{20{inst[31]}}, inst[31:20]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (inst[6:0])
            7'b0110011: begin
                uses_rs2       = 1'b1;
                dec_ctl.reg_we = 1'b1;
                if (inst[31:25] == 7'b0100000 && inst[14:12] == 3'b000) begin
                    dec_ctl.alu = ALU_SUB;
                end else if (inst[31:25] == 7'b0000000) begin
                    case (inst[14:12])
                        3'b000:  dec_ctl.alu = ALU_ADD;
                        3'b010:  dec_ctl.alu = ALU_SLT;
                        3'b100:  dec_ctl.alu = ALU_XOR;
                        3'b110:  dec_ctl.alu = ALU_OR;
                        3'b111:  dec_ctl.alu = ALU_AND;
                        default: dec_ctl.reg_we = 1'b0;
                    endcase
                end else begin
                    dec_ctl.reg_we = 1'b0;
                end
            end
            7'b0010011: begin
                dec_ctl.reg_we  = 1'b1;
                dec_ctl.use_imm = 1'b1;
                case (inst[14:12])
                    3'b000:  dec_ctl.alu = ALU_ADD;
                    3'b110:  dec_ctl.alu = ALU_OR;
                    3'b111:  dec_ctl.alu = ALU_AND;
                    default: dec_ctl.reg_we = 1'b0;
                endcase
            end
            7'b0000011: begin
                if (inst[14:12] == 3'b010) begin
                    dec_ctl.reg_we  = 1'b1;
                    dec_ctl.mem_re  = 1'b1;
                    dec_ctl.use_imm = 1'b1;
                end else begin
                    dec_ctl.mem_re = 1'b0;
                end
            end
            7'b0100011: begin
                uses_rs2 = 1'b1;
                dec_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                if (inst[14:12] == 3'b010) begin
                    dec_ctl.mem_we  = 1'b1;
                    dec_ctl.use_imm = 1'b1;
                end else begin
                    dec_ctl.mem_we = 1'b0;
                end
            end
            7'b1100011: begin
                uses_rs2 = 1'b1;
                dec_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                if (inst[14:13] == 2'b00) begin
                    dec_ctl.branch = 1'b1;
                    dec_ctl.bne    = inst[12];
                end else begin
                    dec_ctl.branch = 1'b0;
                end
            end
            7'b1101111: begin
                uses_rs1       = 1'b0;
                dec_imm        = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                dec_ctl.jal    = 1'b1;
                dec_ctl.reg_we = 1'b1;
            end
            7'b0110111: begin
                uses_rs1       = 1'b0;
                dec_imm        = {inst[31:12], 12'd0};
                dec_ctl.lui    = 1'b1;
                dec_ctl.reg_we = 1'b1;
            end
            default: dec_ctl = '0;
        endcase
    end

    assign load_use = idex_q.ctl.mem_re && (idex_q.rd != 5'd0) &&
                      ((uses_rs1 && inst[19:15] == idex_q.rd) || (uses_rs2 && inst[24:20] == idex_q.rd));

    // EX: forwarding (EX/MEM wins over MEM/WB), ALU and branch resolution.
    always_comb begin
        if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1)    fwd_a = exmem_q.alu;
        else if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) fwd_a = memwb_q.res;
        else                                                                        fwd_a = idex_q.a;
        if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2)    fwd_b = exmem_q.alu;
        else if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) fwd_b = memwb_q.res;
        else                                                                        fwd_b = idex_q.b;
        alu_b = idex_q.ctl.use_imm ? idex_q.imm : fwd_b;
        case (idex_q.ctl.alu)
            ALU_ADD: alu_out = fwd_a + alu_b;
            ALU_SUB: alu_out = fwd_a - alu_b;
            ALU_AND: alu_out = fwd_a & alu_b;
            ALU_OR:  alu_out = fwd_a | alu_b;
            ALU_XOR: alu_out = fwd_a ^ alu_b;
            ALU_SLT: alu_out = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            default: alu_out = fwd_a + alu_b;
        endcase
        if (idex_q.ctl.jal)      ex_res = idex_q.pc + 32'd4;
        else if (idex_q.ctl.lui) ex_res = idex_q.imm;
        else                     ex_res = alu_out;
        taken  = idex_q.ctl.jal ||
                 (idex_q.ctl.branch && (idex_q.ctl.bne ? (fwd_a != fwd_b) : (fwd_a == fwd_b)));
        target = idex_q.pc + idex_q.imm;
    end

    assign mem_res = exmem_q.mem_re ? dmem_rdata : exmem_q.alu;

    // Next-state: redirect outranks the load-use interlock.
    always_comb begin
        if (taken) begin
            pc_d   = target;
            ifid_d = IFID_BUBBLE;
            idex_d = '0;
        end else if (load_use) begin
            pc_d   = pc_cur;
            ifid_d = ifid_q;
            idex_d = '0;
        end else begin
            pc_d   = pc_cur + 32'd4;
            ifid_d = '{pc: pc_cur, inst: imem_rdata};
            idex_d = '{ctl: dec_ctl, rs1: inst[19:15], rs2: inst[24:20], rd: inst[11:7],
                       pc: ifid_q.pc, a: rf_rd1, b: rf_rd2, imm: dec_imm};
        end
        exmem_d = '{reg_we: idex_q.ctl.reg_we, mem_re: idex_q.ctl.mem_re, mem_we: idex_q.ctl.mem_we,
                    rd: idex_q.rd, alu: ex_res, sd: fwd_b};
        memwb_d = '{reg_we: exmem_q.reg_we, rd: exmem_q.rd, res: mem_res};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ifid_q  <= IFID_BUBBLE;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end
endmodule

// File: tb/tb_pipeline_top.sv
// Directed-program bench for pipeline_top: loads small RV32I programs and checks
// architectural state and PC timing through the hierarchical probe points.

module tb_pipeline_top;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    logic [31:0] prog [0:31];

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP_LD  = 7'b0000011;

    pipeline_top dut (.CLK(CLK), .RST(RST));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = NOP;
    endtask

    // Hold reset, load the program, release on a falling edge; next rising edge is edge 1.
    task automatic restart();
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 256; i++) dut.INST_MEM.sub1.RAM_matrix[i] <= (i < 32) ? prog[i] : NOP;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    function automatic logic [31:0] xr(input int idx);
        return dut.register_file.registers[idx];
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("reset_pc", dut.PC.OUT, 32'd0);
        check("reset_x1", xr(1), 32'd0);

        // Back-to-back dependent ALU ops: forwarding, no stall.
        clear_prog();
        prog[0] = i_t(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog[1] = i_t(12'd7, 5'd0, 3'b000, 5'd2, OP_IMM);
        prog[2] = r_t(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
        restart();
        tick(6);
        check("fwd_x2_edge6", xr(2), 32'd7);
        check("fwd_x3_edge6", xr(3), 32'd0);
        tick(1);
        check("fwd_x3_edge7", xr(3), 32'd12);
        check("fwd_pc_edge7", dut.PC.OUT, 32'd28);

        // Load-use: exactly one stall cycle.
        clear_prog();
        prog[0] = i_t(12'd16, 5'd0, 3'b000, 5'd9, OP_IMM);
        prog[1] = s_t(12'd0, 5'd9, 5'd0);
        prog[2] = i_t(12'd0, 5'd0, 3'b010, 5'd4, OP_LD);
        prog[3] = r_t(7'b0000000, 5'd4, 5'd4, 3'b000, 5'd5);
        restart();
        tick(5);
        check("lu_pc_hold", dut.PC.OUT, 32'd16);
        tick(2);
        check("lu_x4", xr(4), 32'h10);
        tick(1);
        check("lu_x5_edge8", xr(5), 32'd0);
        tick(1);
        check("lu_x5_edge9", xr(5), 32'h20);
        check("lu_pc_edge9", dut.PC.OUT, 32'd32);
        check("lu_dmem0", dut.DATA_MEM.sub1.RAM_matrix[0], 32'h10);

        // Taken BEQ and forwarded BNE flush the two younger instructions.
        clear_prog();
        prog[0] = b_t(13'd12, 5'd0, 5'd0, 3'b000);
        prog[1] = i_t(12'd1, 5'd0, 3'b000, 5'd6, OP_IMM);
        prog[2] = i_t(12'd1, 5'd0, 3'b000, 5'd7, OP_IMM);
        prog[3] = i_t(12'd3, 5'd0, 3'b000, 5'd8, OP_IMM);
        prog[4] = b_t(13'd8, 5'd0, 5'd8, 3'b001);
        prog[5] = i_t(12'd1, 5'd0, 3'b000, 5'd9, OP_IMM);
        prog[6] = i_t(12'd2, 5'd0, 3'b000, 5'd10, OP_IMM);
        restart();
        tick(7);
        check("br_bne_pc", dut.PC.OUT, 32'd24);
        tick(7);
        check("br_x6", xr(6), 32'd0);
        check("br_x7", xr(7), 32'd0);
        check("br_x8", xr(8), 32'd3);
        check("br_x9", xr(9), 32'd0);
        check("br_x10", xr(10), 32'd2);

        // Store then load of the same word.
        clear_prog();
        prog[0] = i_t(12'h055, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog[1] = s_t(12'd8, 5'd1, 5'd0);
        prog[2] = i_t(12'd8, 5'd0, 3'b010, 5'd2, OP_LD);
        restart();
        tick(10);
        check("st_dmem2", dut.DATA_MEM.sub1.RAM_matrix[2], 32'h55);
        check("ld_x2", xr(2), 32'h55);

        // ALU op coverage, sign handling, LUI and an unsupported R-type (SLL) as NOP.
        clear_prog();
        prog[0]  = i_t(12'hFFD, 5'd0, 3'b000, 5'd1, OP_IMM);
        prog[1]  = i_t(12'd5, 5'd0, 3'b000, 5'd2, OP_IMM);
        prog[2]  = r_t(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3);
        prog[3]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd4);
        prog[4]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd5);
        prog[5]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd6);
        prog[6]  = r_t(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd7);
        prog[7]  = {20'h12345, 5'd8, 7'b0110111};
        prog[8]  = r_t(7'b0000000, 5'd2, 5'd2, 3'b001, 5'd9);
        prog[9]  = i_t(12'h0F0, 5'd1, 3'b111, 5'd10, OP_IMM);
        prog[10] = i_t(12'hFF0, 5'd2, 3'b110, 5'd11, OP_IMM);
        prog[11] = i_t(12'd4, 5'd1, 3'b000, 5'd12, OP_IMM);
        restart();
        tick(18);
        check("alu_addi_neg", xr(1), 32'hFFFF_FFFD);
        check("alu_sub", xr(3), 32'd8);
        check("alu_slt", xr(4), 32'd1);
        check("alu_xor", xr(5), 32'hFFFF_FFF8);
        check("alu_and", xr(6), 32'd5);
        check("alu_or", xr(7), 32'hFFFF_FFFD);
        check("alu_lui", xr(8), 32'h1234_5000);
        check("alu_unsup_nop", xr(9), 32'd0);
        check("alu_andi", xr(10), 32'h0000_00F0);
        check("alu_ori", xr(11), 32'hFFFF_FFF5);
        check("alu_addi_wrap", xr(12), 32'd1);

        // x0 write ignored; JAL at 0x10 links 0x14 and redirects to 0x18.
        clear_prog();
        prog[0] = i_t(12'd9, 5'd0, 3'b000, 5'd0, OP_IMM);
        prog[4] = j_t(21'd8, 5'd1);
        prog[5] = i_t(12'd1, 5'd0, 3'b000, 5'd10, OP_IMM);
        prog[6] = i_t(12'd2, 5'd0, 3'b000, 5'd11, OP_IMM);
        prog[7] = i_t(12'd3, 5'd0, 3'b000, 5'd12, OP_IMM);
        restart();
        tick(7);
        check("jal_pc", dut.PC.OUT, 32'h18);
        tick(2);
        check("jal_x1", xr(1), 32'h14);
        tick(5);
        check("x0_zero", xr(0), 32'd0);
        check("jal_flush_x10", xr(10), 32'd0);
        check("jal_x11", xr(11), 32'd2);
        check("jal_x12", xr(12), 32'd3);

        // Asynchronous reset mid-run, held for several edges, then release.
        #2 RST = 1'b1;
        #1;
        check("midrst_pc", dut.PC.OUT, 32'd0);
        check("midrst_x1", xr(1), 32'd0);
        check("midrst_x11", xr(11), 32'd0);
        tick(3);
        check("midrst_hold_pc", dut.PC.OUT, 32'd0);
        check("midrst_hold_x12", xr(12), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick(9);
        check("midrst_rerun_x1", xr(1), 32'h14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
